// File: rtl/room_dir_input_cond.sv
// Direction-button conditioner for the room-navigation FSM.
// Synchronises and debounces four raw buttons, then turns a single clean press
// into exactly one one-hot move pulse; simultaneous presses raise a conflict
// pulse instead, and nothing new is accepted until every button is released.
module room_dir_input_cond #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  input  logic btn_s,
  input  logic btn_e,
  input  logic btn_w,
  output logic n,
  output logic s,
  output logic e,
  output logic w,
  output logic busy,
  output logic conflict
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    WAIT_REL
  } state_t;

  // Bit order everywhere: [0]=north, [1]=south, [2]=east, [3]=west.
  logic [3:0]       btn;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic [3:0]       db;
  logic [3:0]       db_q;
  logic [3:0]       press;
  logic [CNT_W-1:0] cnt [4];

  state_t     state;
  state_t     state_next;
  logic [3:0] dir;
  logic [3:0] dir_next;
  logic       conflict_q;
  logic       conflict_next;
  logic       press_one;
  logic       press_multi;

  assign btn = {btn_w, btn_e, btn_s, btn_n};

  // Two-flop synchroniser per button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Debounce: the level only follows sync2 after DEBOUNCE_CYCLES consecutive mismatching edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] != db[i]) begin
          if (cnt[i] == CNT_LAST) begin
            db[i]  <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  // Delayed debounced level for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_q <= '0;
    end else begin
      db_q <= db;
    end
  end

  // Press classification: none, exactly one, or a multi-button combination.
  always_comb begin
    press       = db & ~db_q;
    press_one   = $onehot(press);
    press_multi = (press != '0) && !$onehot(press);
  end

  // FSM state register, latched direction and registered conflict flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dir        <= '0;
      conflict_q <= 1'b0;
    end else begin
      state      <= state_next;
      dir        <= dir_next;
      conflict_q <= conflict_next;
    end
  end

  // Next-state logic; presses outside IDLE are dropped rather than queued.
  always_comb begin
    state_next    = state;
    dir_next      = dir;
    conflict_next = 1'b0;
    case (state)
      IDLE: begin
        if (press_one) begin
          dir_next   = press;
          state_next = EMIT;
        end else if (press_multi) begin
          conflict_next = 1'b1;
          state_next    = WAIT_REL;
        end
      end
      EMIT: begin
        state_next = WAIT_REL;
      end
      WAIT_REL: begin
        if (db == '0) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs decoded from flops only; dir is one-hot so moves stay exclusive.
  always_comb begin
    n        = (state == EMIT) && dir[0];
    s        = (state == EMIT) && dir[1];
    e        = (state == EMIT) && dir[2];
    w        = (state == EMIT) && dir[3];
    busy     = (state != IDLE);
    conflict = conflict_q;
  end

endmodule

// File: tb/tb_room_dir_input_cond.sv
// Self-checking bench for room_dir_input_cond: a table of press scenarios with
// expected pulse counts, hand-written timing/reset sequences, and a randomized
// phase compared cycle by cycle against a window-based reference model.
module tb_room_dir_input_cond;

  localparam int D = 4;
  localparam bit [31:0] WMASK = (32'h1 << D) - 32'h1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_n = 1'b0;
  logic btn_s = 1'b0;
  logic btn_e = 1'b0;
  logic btn_w = 1'b0;
  logic n, s, e, w, busy, conflict;

  int checks = 0;
  int failures = 0;

  room_dir_input_cond #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .reset(reset),
    .btn_n(btn_n),
    .btn_s(btn_s),
    .btn_e(btn_e),
    .btn_w(btn_w),
    .n(n),
    .s(s),
    .e(e),
    .w(w),
    .busy(busy),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  // Reference model: a debounced level flips once the last D synchronised
  // samples all disagree with it; an idle conditioner accepts a lone rising
  // edge (one pulse next cycle) or flags a multi-edge conflict, then stays
  // busy until every debounced level is low again.
  bit [3:0]  m_s1, m_s2, m_db, m_dbp;
  bit [31:0] m_win [4];
  bit        m_busy, m_conf;
  int        m_dir;

  always @(posedge clk or negedge reset) begin : model
    bit [3:0] press, db_old;
    int pc, idx;
    bit nb, nc;
    int nd;
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_dbp = '0;
      for (int i = 0; i < 4; i++) m_win[i] = '0;
      m_busy = 1'b0; m_conf = 1'b0; m_dir = -1;
    end else begin
      db_old = m_db;
      press  = db_old & ~m_dbp;
      pc     = $countones(press);
      idx    = -1;
      for (int i = 0; i < 4; i++) if (press[i]) idx = i;
      nb = m_busy; nc = 1'b0; nd = -1;
      if (!m_busy) begin
        if (pc == 1) begin nb = 1'b1; nd = idx; end
        else if (pc > 1) begin nb = 1'b1; nc = 1'b1; end
      end else if (m_dir >= 0) begin
        nb = 1'b1;
      end else if (db_old == 4'b0000) begin
        nb = 1'b0;
      end
      m_busy = nb; m_conf = nc; m_dir = nd;
      for (int i = 0; i < 4; i++) begin
        m_win[i] = ((m_win[i] << 1) | {31'b0, m_s2[i]}) & WMASK;
        if (m_win[i] == (db_old[i] ? 32'h0 : WMASK)) m_db[i] = ~db_old[i];
      end
      m_dbp = db_old;
      m_s2  = m_s1;
      m_s1  = {btn_w, btn_e, btn_s, btn_n};
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [5:0] exp_v;
    exp_v = {m_dir == 0, m_dir == 1, m_dir == 2, m_dir == 3, m_busy, m_conf};
    checks++;
    if ({n, s, e, w, busy, conflict} !== exp_v) begin
      failures++;
      $display("FAIL model_cmp t=%0t got=%b exp=%b", $time, {n, s, e, w, busy, conflict}, exp_v);
    end
  end

  // Pulse counters for scenario-level expectations.
  int pc_n, pc_s, pc_e, pc_w, pc_c;
  always @(negedge clk) begin
    pc_n += int'(n); pc_s += int'(s); pc_e += int'(e); pc_w += int'(w);
    pc_c += int'(conflict);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp_v);
    end
  endtask

  task automatic drive(input logic [3:0] b);
    {btn_w, btn_e, btn_s, btn_n} = b;
  endtask

  task automatic clr_counts();
    pc_n = 0; pc_s = 0; pc_e = 0; pc_w = 0; pc_c = 0;
  endtask

  task automatic chk_counts(input string name, input int en, input int es, input int ee,
                            input int ew, input int ec);
    chk(name, {12'b0, 4'(pc_n), 4'(pc_s), 4'(pc_e), 4'(pc_w), 4'(pc_c)},
        {12'b0, 4'(en), 4'(es), 4'(ee), 4'(ew), 4'(ec)});
  endtask

  task automatic settle(input string name);
    drive(4'b0000);
    repeat (40) @(negedge clk);
    chk(name, {31'b0, busy}, 32'h0);
  endtask

  typedef struct {
    logic [3:0] btn;
    int hold;
    int en, es, ee, ew, ec;
  } vec_t;

  vec_t tbl [9];
  logic [3:0] rb;

  initial begin
    tbl[0] = '{4'b0001, 20, 1, 0, 0, 0, 0};  // lone north, long hold
    tbl[1] = '{4'b0100,  3, 0, 0, 0, 0, 0};  // glitch one cycle short of debounce
    tbl[2] = '{4'b0100,  4, 0, 0, 1, 0, 0};  // shortest accepted press
    tbl[3] = '{4'b0101, 12, 0, 0, 0, 0, 1};  // north+east together
    tbl[4] = '{4'b0100,  8, 0, 0, 1, 0, 0};  // later lone east
    tbl[5] = '{4'b1010,  5, 0, 0, 0, 0, 1};  // south+west together
    tbl[6] = '{4'b1111,  6, 0, 0, 0, 0, 1};  // all four
    tbl[7] = '{4'b1000,  1, 0, 0, 0, 0, 0};  // single-cycle blip
    tbl[8] = '{4'b0010, 30, 0, 1, 0, 0, 0};  // lone south

    clr_counts();
    #1;
    chk("reset_outs", {26'b0, n, s, e, w, busy, conflict}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // Exact latency and busy window for a held north press.
    drive(4'b0001);
    for (int k = 0; k < 32; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("lat_n_k%0d", k), {26'b0, n, s, e, w, busy, conflict},
          {26'b0, k == 6, 3'b000, (k >= 6) && (k <= 25), 1'b0});
      if (k == 19) drive(4'b0000);
    end
    settle("lat_idle");

    foreach (tbl[i]) begin
      clr_counts();
      drive(tbl[i].btn);
      repeat (tbl[i].hold) @(negedge clk);
      drive(4'b0000);
      repeat (40) @(negedge clk);
      chk_counts($sformatf("vec%0d_counts", i), tbl[i].en, tbl[i].es, tbl[i].ee, tbl[i].ew, tbl[i].ec);
      chk($sformatf("vec%0d_idle", i), {31'b0, busy}, 32'h0);
    end

    // Bouncy south press settling high.
    clr_counts();
    for (int k = 0; k < 10; k++) begin
      drive((k % 2 == 0) ? 4'b0010 : 4'b0000);
      @(negedge clk);
    end
    drive(4'b0010);
    repeat (15) @(negedge clk);
    settle("bounce_idle");
    chk_counts("bounce_counts", 0, 1, 0, 0, 0);

    // Second button while first held is ignored; a fresh press later works.
    clr_counts();
    drive(4'b0100);
    repeat (10) @(negedge clk);
    drive(4'b1100);
    repeat (6) @(negedge clk);
    drive(4'b0100);
    repeat (10) @(negedge clk);
    settle("overlap_idle");
    chk_counts("overlap_counts", 0, 0, 1, 0, 0);
    clr_counts();
    drive(4'b1000);
    repeat (10) @(negedge clk);
    settle("w_after_idle");
    chk_counts("w_after_counts", 0, 0, 0, 1, 0);

    // Reset during EMIT clears outputs immediately; held button re-fires.
    drive(4'b0001);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("emit_before_reset", {26'b0, n, s, e, w, busy, conflict}, {26'b0, 6'b100010});
    #2;
    reset = 1'b0;
    #1;
    chk("reset_async", {26'b0, n, s, e, w, busy, conflict}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("post_rst_k%0d", k), {26'b0, n, s, e, w, busy, conflict},
          {26'b0, k == 6, 3'b000, k >= 6, 1'b0});
    end
    settle("post_rst_idle");

    // Randomized button activity, checked every cycle by the model comparator.
    rb = 4'b0000;
    repeat (3000) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(15) == 0) rb[i] = ~rb[i];
      end
      drive(rb);
      @(negedge clk);
    end
    settle("rand_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
